// File: rtl/booth_digit_sequencer.sv
// booth_digit_sequencer
// Radix-4 Booth recoder that streams a latched multiplier as 4-lane
// Double/Negate/Single beats (lowest digits first). The multiplicand rides
// alongside every beat so the downstream word slice can form its partial
// products directly. All beat outputs are registers.
module booth_digit_sequencer #(
   parameter int XW = 16,
   parameter int YW = 8
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [XW-1:0]                          X,
   input  logic [YW-1:0]                          Y,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [3:0]                             Double,
   output logic [3:0]                             Negate,
   output logic [3:0]                             Single,
   output logic [YW-1:0]                          Yout,
   output logic [((XW/8) > 1 ? $clog2(XW/8) : 1)-1:0] beat,
   output logic                                   out_last
);

   localparam int NBEAT = XW / 8;
   localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_t;

   state_t          r_state;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic [BW-1:0]   r_beat;
   logic            r_out_valid;
   logic            r_out_last;
   logic [3:0]      r_double;
   logic [3:0]      r_negate;
   logic [3:0]      r_single;

   logic            w_accept;
   logic [XW:0]     w_src;
   logic [BW-1:0]   w_next_beat;
   logic [8:0]      w_slice;
   logic            w_next_last;
   logic [3:0]      w_double;
   logic [3:0]      w_negate;
   logic [3:0]      w_single;

   // A new operand is taken when idle, or on the final handshake of the
   // current operand so back-to-back operands stream without a bubble.
   assign in_ready = (r_state == S_IDLE) |
                     ((r_state == S_BUSY) & r_out_valid & out_ready & r_out_last);
   assign w_accept = in_valid & in_ready;

   // Select the 9-bit window for the beat about to be loaded: either beat 0
   // of the incoming operand, or the next beat of the latched one. The
   // window's LSB is the boundary bit X[8k-1] (implicit 0 below bit 0).
   always_comb begin
      w_src       = w_accept ? {X, 1'b0} : {r_x, 1'b0};
      w_next_beat = w_accept ? '0 : (r_beat + BW'(1));
      w_slice     = w_src[8*int'(w_next_beat) +: 9];
      w_next_last = (w_next_beat == LAST_BEAT);
   end

   // One Booth encoder per lane; triplet for lane gi is w_slice[2gi+2:2gi].
   // Triplet 111 deliberately yields Negate=1 with zero magnitude.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_negate[gi] = w_slice[2*gi+2];
         assign w_single[gi] = w_slice[2*gi+1] ^ w_slice[2*gi];
         assign w_double[gi] = ( w_slice[2*gi+2] & ~w_slice[2*gi+1] & ~w_slice[2*gi]) |
                               (~w_slice[2*gi+2] &  w_slice[2*gi+1] &  w_slice[2*gi]);
      end
   endgenerate

   // Sequencer FSM with registered beat outputs; all outputs hold while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_beat      <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_double    <= '0;
         r_negate    <= '0;
         r_single    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_state     <= S_BUSY;
                  r_x         <= X;
                  r_y         <= Y;
                  r_beat      <= w_next_beat;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_next_last;
                  r_double    <= w_double;
                  r_negate    <= w_negate;
                  r_single    <= w_single;
               end
            end
            S_BUSY: begin
               if (out_ready) begin
                  if (!r_out_last || in_valid) begin
                     // Advance within the operand, or chain straight into the next one.
                     if (w_accept) begin
                        r_x <= X;
                        r_y <= Y;
                     end
                     r_beat      <= w_next_beat;
                     r_out_last  <= w_next_last;
                     r_double    <= w_double;
                     r_negate    <= w_negate;
                     r_single    <= w_single;
                  end else begin
                     r_state     <= S_IDLE;
                     r_beat      <= '0;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_double    <= '0;
                     r_negate    <= '0;
                     r_single    <= '0;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign beat      = r_beat;
   assign Yout      = r_y;
   assign Double    = r_double;
   assign Negate    = r_negate;
   assign Single    = r_single;

endmodule

// File: tb/tb_booth_digit_sequencer.sv
// tb_booth_digit_sequencer
// Scoreboard bench: the stimulus pushes expected beats when an operand is
// accepted; a negedge monitor pops and compares on every output handshake,
// and also rebuilds the signed multiplier value from the emitted digits.
module tb_booth_digit_sequencer;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] X;
   logic [7:0]  Y;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  Double;
   logic [3:0]  Negate;
   logic [3:0]  Single;
   logic [7:0]  Yout;
   logic [0:0]  beat;
   logic        out_last;

   logic        rdy_man;
   logic        rnd_en;
   logic        rnd_bit;
   assign out_ready = rnd_en ? rnd_bit : rdy_man;

   booth_digit_sequencer #(.XW(16), .YW(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
      .out_valid(out_valid), .out_ready(out_ready),
      .Double(Double), .Negate(Negate), .Single(Single),
      .Yout(Yout), .beat(beat), .out_last(out_last)
   );

   typedef struct packed {
      logic [3:0]  d;
      logic [3:0]  n;
      logic [3:0]  s;
      logic [7:0]  y;
      logic        b;
      logic        last;
      logic [15:0] x;
   } exp_t;

   exp_t sb[$];
   int   hs_cyc[$];
   int   n_vec;
   int   n_bad;
   int   cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Random backpressure source for the sweep section.
   initial begin
      rnd_bit = 1'b1;
      forever begin
         @(posedge clk);
         #1 rnd_bit = ($urandom_range(0, 3) != 0);
      end
   end

   // Reference recoder: builds each digit's signed value, then classifies it.
   function automatic logic [11:0] model_beat(input logic [15:0] x, input int k);
      logic [16:0] xe;
      logic [3:0]  d, n, s;
      int          v;
      int          i;
      xe = {x, 1'b0};
      for (int j = 0; j < 4; j++) begin
         i = 4*k + j;
         v = -2*int'(xe[2*i+2]) + int'(xe[2*i+1]) + int'(xe[2*i]);
         d[j] = (v == 2) || (v == -2);
         s[j] = (v == 1) || (v == -1);
         n[j] = xe[2*i+2];
      end
      return {d, n, s};
   endfunction

   // Monitor: compare each handshake beat against the scoreboard head.
   initial begin
      exp_t e;
      int   acc;
      int   v;
      acc = 0;
      forever begin
         @(negedge clk);
         if (reset_n && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            n_vec++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_beat: got beat=%0d D=%b N=%b S=%b, required no beat", beat, Double, Negate, Single);
            end else begin
               e = sb.pop_front();
               if ({Double, Negate, Single, Yout, beat, out_last} !== {e.d, e.n, e.s, e.y, e.b, e.last}) begin
                  n_bad++;
                  $display("FAIL beat X=%h k=%0d: got D=%b N=%b S=%b Y=%h beat=%0d last=%b, required D=%b N=%b S=%b Y=%h beat=%0d last=%b",
                           e.x, e.b, Double, Negate, Single, Yout, beat, out_last, e.d, e.n, e.s, e.y, e.b, e.last);
               end
               n_vec++;
               if (in_ready !== e.last) begin
                  n_bad++;
                  $display("FAIL in_ready X=%h k=%0d: got %b, required %b", e.x, e.b, in_ready, e.last);
               end
               if (beat == 1'b0) acc = 0;
               for (int j = 0; j < 4; j++) begin
                  v = Single[j] ? 1 : (Double[j] ? 2 : 0);
                  if (Negate[j]) v = -v;
                  acc += v * (4 ** (4*int'(beat) + j));
               end
               if (e.last) begin
                  n_vec++;
                  if (acc != int'($signed(e.x))) begin
                     n_bad++;
                     $display("FAIL digit_sum X=%h: got %0d, required %0d", e.x, acc, int'($signed(e.x)));
                  end
               end
            end
         end
      end
   end

   // Offer an operand until accepted (bounded), pushing its expected beats.
   task automatic issue(input logic [15:0] x, input logic [7:0] y,
                        input logic [11:0] b0, input logic [11:0] b1);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      X        = x;
      Y        = y;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back({b0, y, 1'b0, 1'b0, x});
            sb.push_back({b1, y, 1'b1, 1'b1, x});
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout X=%h: got in_ready=0 for 200 cycles, required acceptance", x);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: got %0d beats outstanding, required 0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   logic [15:0] rx;

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      cyc      = 0;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      X        = '0;
      Y        = '0;
      rdy_man  = 1'b1;
      rnd_en   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, Double, Negate, Single, Yout, beat, out_last} !== {1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b D=%b N=%b S=%b Y=%h beat=%0d last=%b, required rdy=1 and all others 0",
                  in_ready, out_valid, Double, Negate, Single, Yout, beat, out_last);
      end
      @(posedge clk);
      #1;

      // Directed operands, hand-computed {D,N,S} per beat
      issue(16'h0000, 8'h5A, 12'b0000_0000_0000, 12'b0000_0000_0000);
      drain();
      issue(16'hFFFF, 8'h11, 12'b0000_1111_0001, 12'b0000_1111_0000);
      drain();
      issue(16'h0002, 8'h22, 12'b0001_0001_0010, 12'b0000_0000_0000);
      drain();
      issue(16'h8000, 8'h33, 12'b0000_0000_0000, 12'b1000_1000_0000);
      drain();

      // Back-to-back operands at full rate: 4 beats in 4 consecutive cycles
      hs_cyc.delete();
      issue(16'h5555, 8'h44, 12'b0000_0000_1111, 12'b0000_0000_1111);
      issue(16'hAAAA, 8'h55, 12'b0001_1111_1110, 12'b0000_1111_1111);
      drain();
      n_vec++;
      if (hs_cyc.size() != 4 || (hs_cyc[3] - hs_cyc[0]) != 3) begin
         n_bad++;
         $display("FAIL back_to_back: got %0d beats spanning %0d cycles, required 4 beats spanning 3",
                  hs_cyc.size(), (hs_cyc.size() == 4) ? hs_cyc[3] - hs_cyc[0] : -1);
      end

      // Stall on beat 0 for 3 cycles, then reset mid-operation
      rdy_man = 1'b0;
      issue(16'hAAAA, 8'h3C, 12'b0001_1111_1110, 12'b0000_1111_1111);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if ({out_valid, in_ready, Double, Negate, Single, Yout, beat, out_last} !==
             {1'b1, 1'b0, 4'b0001, 4'b1111, 4'b1110, 8'h3C, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_hold c=%0d: got vld=%b rdy=%b D=%b N=%b S=%b Y=%h beat=%0d last=%b, required vld=1 rdy=0 D=0001 N=1111 S=1110 Y=3c beat=0 last=0",
                     c, out_valid, in_ready, Double, Negate, Single, Yout, beat, out_last);
         end
      end
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid, Double, Negate, Single, Yout, beat, out_last} !== {1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL midop_reset: got rdy=%b vld=%b D=%b N=%b S=%b Y=%h beat=%0d last=%b, required rdy=1 and all others 0",
                  in_ready, out_valid, Double, Negate, Single, Yout, beat, out_last);
      end
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      rdy_man = 1'b1;

      // Random sweep with random backpressure; digit sum checked by the monitor
      rnd_en = 1'b1;
      for (int r = 0; r < 24; r++) begin
         rx = 16'($urandom);
         issue(rx, 8'($urandom), model_beat(rx, 0), model_beat(rx, 1));
      end
      drain();
      rnd_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
